// File: rtl/axi_bridge_pkg.sv
// axi_bridge_pkg: shared state encodings, AXI constants and line-address helper
// for the cache-to-AXI burst bridge.
package axi_bridge_pkg;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B = 3'b010;
    localparam logic [3:0] WB_AXI_ID = 4'd1;
    function automatic logic [31:0] line_addr(input logic [31:0] a, input int off_w);
        return a & ~((32'd1 << off_w) - 32'd1);
    endfunction
endpackage

// File: rtl/axi_burst_bridge_rr_arbiter.sv
// rr_arbiter: round-robin arbiter; the search starts one past the last winner,
// and the pointer only moves when advance is high and someone actually won.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    logic [IW-1:0] ptr_q, sel, j;
    logic found;
    always_comb begin
        gnt = '0;
        sel = ptr_q;
        j = ptr_q;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            j = IW'((int'(ptr_q) + i) % N);
            if (!found && req[j]) begin
                found = 1'b1;
                sel = j;
                gnt[j] = 1'b1;
            end
        end
    end
    always_ff @(posedge aclk) begin
        if (!aresetn) ptr_q <= IW'(N - 1);
        else if (advance && found) ptr_q <= sel;
    end
endmodule

// File: rtl/axi_burst_bridge.sv
// axi_burst_bridge: NUM_RD cache line-read ports and one write-back port onto a single AXI3 master.
// Optional BRIDGE_RAW_CHECK_EN holds back reads that hit the line currently being written back.
module axi_burst_bridge
    import axi_bridge_pkg::*;
#(
    parameter int NUM_RD = 2,
    parameter int LINE_WORDS = 16,
    parameter int IDX_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [NUM_RD-1:0]       rd_req,
    input  logic [NUM_RD*32-1:0]    rd_addr,
    output logic [NUM_RD-1:0]       rd_rdy,
    output logic [NUM_RD-1:0]       ret_valid,
    output logic                    ret_last,
    output logic [31:0]             ret_data,
    input  logic                    wr_req,
    input  logic [31:0]             wr_addr,
    input  logic [LINE_WORDS*32-1:0] wr_data,
    output logic                    wr_rdy,
    output logic [3:0]              arid,
    output logic [31:0]             araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [3:0]              rid,
    input  logic [31:0]             rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [3:0]              awid,
    output logic [31:0]             awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [3:0]              wid,
    output logic [31:0]             wdata,
    output logic [3:0]              wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [3:0]              bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);
    localparam int OFF_W = $clog2(LINE_WORDS * 4);
    localparam int BW = $clog2(LINE_WORDS);

    rd_state_e r_state_q;
    wr_state_e w_state_q;
    logic [IDX_W-1:0] grant_q, gidx;
    logic [31:0] raddr_q, gaddr, waddr_q;
    logic [LINE_WORDS*32-1:0] wbuf_q;
    logic [BW-1:0] beat_q;
    logic [NUM_RD-1:0] raw_mask, gnt;
    logic r_idle, r_match;
    logic unused_ok;

    assign unused_ok = ^{rresp, bresp, bid};

`ifdef BRIDGE_RAW_CHECK_EN
    // Mask stays up until bvalid, so the read sees memory after the write lands.
    always_comb begin
        raw_mask = '0;
        for (int i = 0; i < NUM_RD; i++)
            raw_mask[i] = (w_state_q != W_IDLE) &&
                          (line_addr(rd_addr[32*i +: 32], OFF_W) == line_addr(waddr_q, OFF_W));
    end
`else
    assign raw_mask = '0;
`endif

    assign r_idle = (r_state_q == R_IDLE);

    rr_arbiter #(.N(NUM_RD)) u_arb (
        .aclk    (aclk),
        .aresetn (aresetn),
        .req     (rd_req & ~raw_mask),
        .advance (r_idle),
        .gnt     (gnt)
    );

    always_comb begin
        gidx = '0;
        gaddr = '0;
        for (int i = 0; i < NUM_RD; i++)
            if (gnt[i]) begin
                gidx = IDX_W'(i);
                gaddr = rd_addr[32*i +: 32];
            end
    end

    assign rd_rdy    = r_idle ? gnt : '0;
    assign r_match   = (r_state_q == R_DATA) && rvalid && (rid == 4'(grant_q));
    assign ret_valid = r_match ? (NUM_RD'(1) << grant_q) : '0;
    assign ret_last  = r_match && rlast;
    assign ret_data  = rdata;
    assign arvalid   = (r_state_q == R_ADDR);
    assign araddr    = line_addr(raddr_q, OFF_W);
    assign arlen     = 8'(LINE_WORDS - 1);
    assign arsize    = AXI_SIZE_4B;
    assign arburst   = AXI_BURST_INCR;
    assign arid      = 4'(grant_q);
    assign rready    = (r_state_q == R_DATA);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            grant_q <= '0;
            raddr_q <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: if (|gnt) begin
                    grant_q <= gidx;
                    raddr_q <= gaddr;
                    r_state_q <= R_ADDR;
                end
                R_ADDR: if (arready) r_state_q <= R_DATA;
                R_DATA: if (r_match && rlast) r_state_q <= R_IDLE;
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign wr_rdy  = (w_state_q == W_IDLE) && wr_req;
    assign awvalid = (w_state_q == W_ADDR);
    assign awaddr  = line_addr(waddr_q, OFF_W);
    assign awlen   = 8'(LINE_WORDS - 1);
    assign awsize  = AXI_SIZE_4B;
    assign awburst = AXI_BURST_INCR;
    assign awid    = WB_AXI_ID;
    assign wvalid  = (w_state_q == W_DATA);
    assign wdata   = wbuf_q[32*beat_q +: 32];
    assign wstrb   = 4'hF;
    assign wid     = WB_AXI_ID;
    assign wlast   = wvalid && (beat_q == BW'(LINE_WORDS - 1));
    assign bready  = (w_state_q == W_RESP);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            waddr_q <= '0;
            wbuf_q <= '0;
            beat_q <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: if (wr_req) begin
                    waddr_q <= wr_addr;
                    wbuf_q <= wr_data;
                    beat_q <= '0;
                    w_state_q <= W_ADDR;
                end
                W_ADDR: if (awready) w_state_q <= W_DATA;
                W_DATA: if (wready) begin
                    beat_q <= beat_q + 1'b1;
                    if (wlast) w_state_q <= W_RESP;
                end
                W_RESP: if (bvalid) w_state_q <= W_IDLE;
                default: w_state_q <= W_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_burst_bridge.sv
// tb_axi_burst_bridge: directed read-vector table plus hand-written write-back,
// concurrency, RAW-ordering and reset sequences against a small AXI slave model.
module tb_axi_burst_bridge;
    localparam int LW = 16;

    logic aclk = 1'b0, aresetn = 1'b0;
    logic [1:0] rd_req = '0, rd_rdy, ret_valid;
    logic [63:0] rd_addr = '0;
    logic ret_last;
    logic [31:0] ret_data;
    logic wr_req = 1'b0, wr_rdy;
    logic [31:0] wr_addr = '0;
    logic [LW*32-1:0] wr_data = '0;
    logic [3:0] arid, rid = '0, awid, wid, bid = '0;
    logic [31:0] araddr, rdata = '0, awaddr, wdata;
    logic [7:0] arlen, awlen;
    logic [2:0] arsize, awsize;
    logic [1:0] arburst, awburst, rresp = '0, bresp = '0;
    logic arvalid, arready = 1'b0, rlast = 1'b0, rvalid = 1'b0, rready;
    logic awvalid, awready = 1'b0, wlast, wvalid, wready = 1'b0, bvalid = 1'b0, bready;
    logic [3:0] wstrb;

    always #5 aclk = ~aclk;

    axi_burst_bridge dut (
        .aclk(aclk), .aresetn(aresetn),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int tests = 0, fails = 0, cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rpat(input logic [31:0] base, input int k);
        return {base[31:8], 8'(k)} ^ 32'h5A5A_0000;
    endfunction

    // slave knobs and state
    int ar_delay = 2, aw_delay = 0, ar_cnt = 0, aw_cnt = 0, r_beat = 0;
    bit w_toggle = 0, inj = 0, r_on = 0, r_bad = 0, w_on = 0, b_on = 0;
    logic [3:0] r_id = '0;
    logic [31:0] r_base = '0;
    // negedge samples
    bit s_ar, s_arv, s_r, s_aw, s_awv, s_w, s_wlast, s_b, s_rst = 1, p_rst = 1;
    bit p_arv, p_ar, p_awv, p_aw, p_wv, p_w;
    logic [31:0] s_araddr, p_araddr, p_wdata;
    logic [3:0] s_arid;
    // monitor records
    int mon_idx = 0, rd_done = 0, w_idx = 0, w_beats = 0, b_cnt = 0;
    int b_cyc = -1, aw_cyc = -1, wv_first = -1, ar_first = -1;
    logic [31:0] exp_line [LW];
    logic [31:0] l_araddr, l_awaddr;
    logic [7:0] l_arlen, l_awlen;
    logic [3:0] l_arid;
    logic [2:0] l_arsize, l_awsize;
    logic [1:0] l_arburst, l_awburst, exp_rv;

    initial forever begin
        @(negedge aclk);
        s_rst = !aresetn;
        if (!p_rst) begin
            if (p_arv && !p_ar) begin
                check("ar_hold", arvalid, 1);
                check("araddr_hold", araddr, p_araddr);
            end
            if (p_awv && !p_aw) check("aw_hold", awvalid, 1);
            if (p_wv && !p_w) begin
                check("w_hold", wvalid, 1);
                check("wdata_hold", wdata, p_wdata);
            end
        end
        s_arv = arvalid; s_ar = arvalid && arready; s_araddr = araddr; s_arid = arid;
        s_awv = awvalid; s_aw = awvalid && awready;
        s_w = wvalid && wready; s_wlast = wlast; s_b = bvalid && bready; s_r = rvalid && rready;
        if (s_ar) begin
            l_araddr = araddr; l_arlen = arlen; l_arid = arid; l_arsize = arsize; l_arburst = arburst;
        end
        if (arvalid && ar_first < 0) ar_first = cyc;
        if (rvalid) begin
            check("rready", rready, 1);
            exp_rv = r_bad ? 2'b00 : 2'(1 << r_id);
            check("ret_valid", ret_valid, exp_rv);
            if (!r_bad) begin
                check("ret_data", ret_data, rpat(r_base, mon_idx));
                check("ret_last", ret_last, mon_idx == LW - 1);
                mon_idx++;
                if (mon_idx == LW) begin mon_idx = 0; rd_done++; end
            end
        end
        if (s_aw) begin aw_cyc = cyc; l_awaddr = awaddr; l_awlen = awlen; l_awsize = awsize; l_awburst = awburst; end
        if (wvalid && wv_first < 0) wv_first = cyc;
        if (s_w) begin
            check("wdata", wdata, exp_line[w_idx]);
            check("wlast", wlast, w_idx == LW - 1);
            check("wid_wstrb", {wid, wstrb}, 8'h1F);
            w_idx = (w_idx + 1) % LW;
            w_beats++;
        end
        if (s_b) begin b_cyc = cyc; b_cnt++; end
        if (s_rst) begin mon_idx = 0; w_idx = 0; end
        p_arv = arvalid; p_ar = s_ar; p_araddr = araddr; p_awv = awvalid; p_aw = s_aw;
        p_wv = wvalid; p_w = s_w; p_wdata = wdata; p_rst = s_rst;
    end

    initial forever begin
        @(posedge aclk);
        #1;
        if (s_rst) begin
            arready = 0; rvalid = 0; rlast = 0; r_on = 0; r_bad = 0; ar_cnt = 0;
            awready = 0; wready = 0; bvalid = 0; w_on = 0; b_on = 0; aw_cnt = 0;
        end else begin
            if (s_ar) begin
                arready = 0; ar_cnt = 0; r_on = 1; r_beat = 0; r_id = s_arid; r_base = s_araddr; r_bad = inj;
            end else if (s_arv && !arready) begin
                if (ar_cnt >= ar_delay) arready = 1; else ar_cnt++;
            end
            if (s_r) begin
                if (r_bad) r_bad = 0;
                else if (r_beat == LW - 1) r_on = 0;
                else r_beat++;
            end
            rvalid = r_on;
            rid = r_bad ? 4'd7 : r_id;
            rdata = r_bad ? 32'hBAD0_0000 : rpat(r_base, r_beat);
            rlast = r_bad || (r_beat == LW - 1);
            if (s_aw) begin
                awready = 0; aw_cnt = 0; w_on = 1;
            end else if (s_awv && !awready) begin
                if (aw_cnt >= aw_delay) awready = 1; else aw_cnt++;
            end
            if (s_w && s_wlast) begin w_on = 0; b_on = 1; end
            wready = w_on ? (w_toggle ? !wready : 1'b1) : 1'b0;
            if (s_b) b_on = 0;
            bvalid = b_on; bid = 4'd1;
        end
    end

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_rdy(input int p);
        @(negedge aclk);
        for (int k = 0; k < 400 && !rd_rdy[p]; k++) @(negedge aclk);
        check("rd_rdy_seen", rd_rdy[p], 1);
    endtask

    task automatic wait_wr_rdy;
        @(negedge aclk);
        for (int k = 0; k < 400 && !wr_rdy; k++) @(negedge aclk);
        check("wr_rdy_seen", wr_rdy, 1);
    endtask

    task automatic wait_done(input int rd_t, input int b_t);
        @(negedge aclk);
        for (int k = 0; k < 400 && (rd_done < rd_t || b_cnt < b_t); k++) @(negedge aclk);
        check("rd_done", rd_done, rd_t);
        check("b_cnt", b_cnt, b_t);
    endtask

    task automatic chk_reset;
        check("rst_rd_rdy", rd_rdy, 0);
        check("rst_ret_valid", ret_valid, 0);
        check("rst_ret_last", ret_last, 0);
        check("rst_wr_rdy", wr_rdy, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_wlast", wlast, 0);
        check("rst_rready", rready, 0);
        check("rst_bready", bready, 0);
    endtask

    typedef struct {
        logic [1:0] req;
        logic [31:0] a0, a1;
        int gnt;
        logic [31:0] exp_araddr;
        bit bad;
    } rv_t;
    rv_t vec [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int rd0, bc0, wb0;
        vec[0] = '{2'b10, 32'h0, 32'h1fc0_0124, 1, 32'h1fc0_0100, 1'b0};
        vec[1] = '{2'b11, 32'h0000_1004, 32'h0000_2008, 0, 32'h0000_1000, 1'b0};
        vec[2] = '{2'b11, 32'h0000_1004, 32'h0000_2008, 1, 32'h0000_2000, 1'b0};
        vec[3] = '{2'b11, 32'h0000_1004, 32'h0000_2008, 0, 32'h0000_1000, 1'b0};
        vec[4] = '{2'b01, 32'hffff_ffff, 32'h0, 0, 32'hffff_ffc0, 1'b0};
        vec[5] = '{2'b10, 32'h0, 32'h8000_003c, 1, 32'h8000_0000, 1'b1};
        repeat (3) @(posedge aclk);
        #1 aresetn = 1;
        @(negedge aclk);
        chk_reset();

        for (int v = 0; v < 6; v++) begin
            tick();
            inj = vec[v].bad;
            rd_addr = {vec[v].a1, vec[v].a0};
            rd_req = vec[v].req;
            rd0 = rd_done;
            wait_rdy(vec[v].gnt);
            check("grant", rd_rdy, 1 << vec[v].gnt);
            tick();
            rd_req[vec[v].gnt] = 1'b0;
            @(negedge aclk);
            check("ar_latency", arvalid, 1);
            wait_done(rd0 + 1, b_cnt);
            check("araddr", l_araddr, vec[v].exp_araddr);
            check("arid", l_arid, vec[v].gnt);
            check("arlen_size_burst", {l_arlen, l_arsize, l_arburst}, {8'd15, 3'b010, 2'b01});
        end
        inj = 0;
        rd_req = '0;

        // write-back: slow awready, toggling wready, wr_req held to probe re-acceptance
        for (int k = 0; k < LW; k++) begin
            exp_line[k] = 32'hA000_0000 + k;
            wr_data[32*k +: 32] = 32'hA000_0000 + k;
        end
        tick();
        aw_delay = 3; w_toggle = 1;
        wr_addr = 32'h0000_4000; wr_req = 1;
        bc0 = b_cnt; wb0 = w_beats;
        wait_wr_rdy();
        wv_first = -1;
        @(negedge aclk);
        check("aw_latency", awvalid, 1);
        check("awid", awid, 1);
        wait_wr_rdy();
        check("wb_b_cnt", b_cnt, bc0 + 1);
        check("wr_rdy_after_b", cyc, b_cyc + 1);
        check("w_after_aw", wv_first, aw_cyc + 1);
        check("w_beats", w_beats, wb0 + 16);
        check("awaddr", l_awaddr, 32'h0000_4000);
        check("awlen_size_burst", {l_awlen, l_awsize, l_awburst}, {8'd15, 3'b010, 2'b01});
        tick();
        wr_req = 0;
        wait_done(rd_done, bc0 + 2);

        // simultaneous read and write-back
        tick();
        aw_delay = 0; w_toggle = 0; ar_delay = 1;
        rd_addr[31:0] = 32'h0000_6010; rd_req = 2'b01;
        wr_addr = 32'h0000_7000; wr_req = 1;
        rd0 = rd_done; bc0 = b_cnt;
        @(negedge aclk);
        check("sim_rd_rdy", rd_rdy, 2'b01);
        check("sim_wr_rdy", wr_rdy, 1);
        tick();
        rd_req = 0; wr_req = 0;
        wait_done(rd0 + 1, bc0 + 1);
        check("sim_araddr", l_araddr, 32'h0000_6000);
        check("sim_awaddr", l_awaddr, 32'h0000_7000);

        // read of the line being written back
        tick();
        aw_delay = 3; w_toggle = 1;
        wr_addr = 32'h0000_2040; wr_req = 1;
        wait_wr_rdy();
        tick();
        wr_req = 0;
        rd_addr[63:32] = 32'h0000_2040; rd_req = 2'b10;
        ar_first = -1; bc0 = b_cnt; rd0 = rd_done;
        wait_rdy(1);
        tick();
        rd_req = 0;
        wait_done(rd0 + 1, bc0 + 1);
        check("raw_araddr", l_araddr, 32'h0000_2040);
        check("raw_arid", l_arid, 1);
`ifdef BRIDGE_RAW_CHECK_EN
        check("raw_ar_after_b", ar_first > b_cyc, 1);
`else
        check("raw_ar_before_b", ar_first < b_cyc, 1);
`endif

        // reset in the middle of a read burst
        tick();
        aw_delay = 0; w_toggle = 0; ar_delay = 2;
        rd_addr[31:0] = 32'h0000_3000; rd_req = 2'b01;
        wait_rdy(0);
        tick();
        rd_req = 0;
        repeat (6) @(negedge aclk);
        check("mid_burst", rready, 1);
        tick();
        aresetn = 0;
        tick();
        aresetn = 1;
        @(negedge aclk);
        chk_reset();
        tick();
        rd_addr = {32'h0000_5000, 32'h0000_3000}; rd_req = 2'b11;
        rd0 = rd_done;
        wait_rdy(0);
        check("post_reset_grant", rd_rdy, 2'b01);
        tick();
        rd_req = 0;
        wait_done(rd0 + 1, b_cnt);
        check("post_reset_araddr", l_araddr, 32'h0000_3000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
